// File: rtl/noc_pkg.sv
// Shared types and constants for the NoC router output port.
package noc_pkg;

  localparam int unsigned FLIT_W   = 8;
  localparam int unsigned PORT_CNT = 5;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } flit_t;

  typedef enum logic [2:0] {
    PORT_N = 3'd0,
    PORT_S = 3'd1,
    PORT_E = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_sel_e;

  localparam logic [PORT_CNT-1:0] TURN_N = 5'b10000;
  localparam logic [PORT_CNT-1:0] TURN_S = 5'b01000;
  localparam logic [PORT_CNT-1:0] TURN_E = 5'b00100;
  localparam logic [PORT_CNT-1:0] TURN_W = 5'b00010;
  localparam logic [PORT_CNT-1:0] TURN_L = 5'b00001;

  // Right-rotate keeps the token one-hot and walks N->S->E->W->L->N.
  function automatic logic [PORT_CNT-1:0] turn_next(input logic [PORT_CNT-1:0] t);
    return {t[0], t[PORT_CNT-1:1]};
  endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit tracker: grants transfers, saturates returns, flags misuse.
module noc_credit_counter #(
  parameter int unsigned CREDITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic ret_i,
  output logic xfer_c,
  output logic full_c,
  output logic err_c
);

  localparam int unsigned CNT_W = $clog2(CREDITS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // A simultaneous grant and return cancel out.
  always_comb begin
    count_d = count_q;
    err_c   = 1'b0;
    xfer_c  = req_i && (count_q != '0);
    if (req_i && (count_q == '0)) err_c = 1'b1;
    if (xfer_c && !ret_i) begin
      count_d = count_q - CNT_W'(1);
    end else if (ret_i && !xfer_c) begin
      if (count_q == CNT_MAX) err_c = 1'b1;
      else                    count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= CNT_MAX;
    else        count_q <= count_d;
  end

  assign full_c = (count_q == '0);

endmodule

// File: rtl/noc_output_port.sv
// Router output port: flit mux/register, turn token, credit flow control.
// Optional statistics counters enabled by NOC_OUTPORT_STATS_EN.
module noc_output_port
  import noc_pkg::*;
#(
  parameter int unsigned         CREDITS    = 4,
  parameter logic [PORT_CNT-1:0] TURN_RESET = TURN_N
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [FLIT_W-1:0]   n_data_i,
  input  logic [FLIT_W-1:0]   s_data_i,
  input  logic [FLIT_W-1:0]   e_data_i,
  input  logic [FLIT_W-1:0]   w_data_i,
  input  logic [FLIT_W-1:0]   l_data_i,
  input  logic [2:0]          port_select_i,
  input  logic                port_enable_i,
  input  logic                credit_ret_i,
  output logic [PORT_CNT-1:0] turn_o,
  output logic                port_full_o,
  output logic [FLIT_W-1:0]   data_o,
  output logic                valid_o,
  output logic                err_o
`ifdef NOC_OUTPORT_STATS_EN
  ,
  output logic [15:0]         flit_cnt_o,
  output logic [15:0]         stall_cnt_o
`endif
);

  logic  legal_c;
  logic  req_c;
  logic  sel_err_c;
  logic  xfer_c;
  logic  cnt_err_c;
  flit_t mux_c;

  assign legal_c   = (port_select_i <= 3'(PORT_L));
  assign req_c     = port_enable_i && legal_c;
  assign sel_err_c = port_enable_i && !legal_c;

  always_comb begin
    mux_c = '0;
    case (port_sel_e'(port_select_i))
      PORT_N:  mux_c = flit_t'(n_data_i);
      PORT_S:  mux_c = flit_t'(s_data_i);
      PORT_E:  mux_c = flit_t'(e_data_i);
      PORT_W:  mux_c = flit_t'(w_data_i);
      PORT_L:  mux_c = flit_t'(l_data_i);
      default: mux_c = '0;
    endcase
  end

  noc_credit_counter #(
    .CREDITS (CREDITS)
  ) u_credit (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req_c),
    .ret_i  (credit_ret_i),
    .xfer_c (xfer_c),
    .full_c (port_full_o),
    .err_c  (cnt_err_c)
  );

  // data_o holds the last flit between transfers; err_o is sticky until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      turn_o  <= TURN_RESET;
      data_o  <= '0;
      valid_o <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      turn_o  <= turn_next(turn_o);
      valid_o <= xfer_c;
      if (xfer_c) data_o <= FLIT_W'(mux_c);
      err_o   <= err_o | cnt_err_c | sel_err_c;
    end
  end

`ifdef NOC_OUTPORT_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      flit_cnt_o  <= flit_cnt_o + 16'(valid_o);
      stall_cnt_o <= stall_cnt_o + 16'(port_full_o);
    end
  end
`endif

endmodule

// File: tb/tb_noc_output_port.sv
// Bench for noc_output_port: vector tables, scoreboard of flits, reset corner cases.
// Also checks statistics outputs when built with NOC_OUTPORT_STATS_EN.
module tb_noc_output_port;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] n_data = '0, s_data = '0, e_data = '0, w_data = '0, l_data = '0;
  logic [2:0] port_select = '0;
  logic       port_enable = 1'b0;
  logic       credit_ret = 1'b0;
  logic [4:0] turn_o;
  logic       port_full_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       err_o;
`ifdef NOC_OUTPORT_STATS_EN
  logic [15:0] flit_cnt_o;
  logic [15:0] stall_cnt_o;
`endif

  noc_output_port #(.CREDITS(4), .TURN_RESET(5'b10000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .n_data_i      (n_data),
    .s_data_i      (s_data),
    .e_data_i      (e_data),
    .w_data_i      (w_data),
    .l_data_i      (l_data),
    .port_select_i (port_select),
    .port_enable_i (port_enable),
    .credit_ret_i  (credit_ret),
    .turn_o        (turn_o),
    .port_full_o   (port_full_o),
    .data_o        (data_o),
    .valid_o       (valid_o),
    .err_o         (err_o)
`ifdef NOC_OUTPORT_STATS_EN
    ,
    .flit_cnt_o    (flit_cnt_o),
    .stall_cnt_o   (stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [2:0] sel;
    logic       ret;
    logic       v;
    logic       f;
    logic       e;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [4:0] exp_turn;
  logic [7:0] exp_last;
  logic       prev_v, prev_f;
  logic [15:0] exp_flit, exp_stall;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic en, input logic [2:0] sel, input logic ret,
                     input logic v, input logic f, input logic e);
    vec_t r;
    r.en = en; r.sel = sel; r.ret = ret; r.v = v; r.f = f; r.e = e;
    tbl.push_back(r);
  endtask

  task automatic model_reset();
    exp_turn  = 5'b10000;
    exp_last  = 8'h00;
    exp_q.delete();
    prev_v    = 1'b0;
    prev_f    = 1'b0;
    exp_flit  = '0;
    exp_stall = '0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_turn"},  16'(turn_o),      16'h0010);
    chk({tag, "_valid"}, 16'(valid_o),     16'h0000);
    chk({tag, "_full"},  16'(port_full_o), 16'h0000);
    chk({tag, "_err"},   16'(err_o),       16'h0000);
    chk({tag, "_data"},  16'(data_o),      16'h0000);
`ifdef NOC_OUTPORT_STATS_EN
    chk({tag, "_flit"},  flit_cnt_o,  16'h0000);
    chk({tag, "_stall"}, stall_cnt_o, 16'h0000);
`endif
  endtask

  // One clock of stimulus; the expected flit is queued as it is driven.
  task automatic step(input vec_t r);
    logic [7:0] d[5];
    logic [7:0] got;
    for (int i = 0; i < 5; i++) d[i] = 8'($urandom);
    n_data = d[0]; s_data = d[1]; e_data = d[2]; w_data = d[3]; l_data = d[4];
    port_enable = r.en; port_select = r.sel; credit_ret = r.ret;
    if (r.v && r.sel < 3'd5) begin
      exp_q.push_back(d[r.sel]);
      exp_last = d[r.sel];
    end
    if (prev_v) exp_flit++;
    if (prev_f) exp_stall++;
    @(posedge clk);
    #1;
    exp_turn = {exp_turn[0], exp_turn[4:1]};
    chk("turn",  16'(turn_o),      16'(exp_turn));
    chk("valid", 16'(valid_o),     16'(r.v));
    chk("full",  16'(port_full_o), 16'(r.f));
    chk("err",   16'(err_o),       16'(r.e));
    chk("data_hold", 16'(data_o),  16'(exp_last));
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb_unexpected actual=%h expected=none", data_o);
      end else begin
        got = exp_q.pop_front();
        chk("sb_data", 16'(data_o), 16'(got));
      end
    end else if (r.v && exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
`ifdef NOC_OUTPORT_STATS_EN
    chk("flit_cnt",  flit_cnt_o,  exp_flit);
    chk("stall_cnt", stall_cnt_o, exp_stall);
`endif
    prev_v = r.v;
    prev_f = r.f;
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  task automatic do_reset(input string tag);
    port_enable = 1'b0; credit_ret = 1'b0; port_select = '0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_state(tag);
    repeat (2) @(posedge clk);
    #1 chk_reset_state({tag, "_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_state("por");
    rst_n = 1'b1;

    // Idle: turn walks, nothing else moves.
    for (int i = 0; i < 10; i++) add(0, 3'd0, 0, 0, 0, 0);
    // Drain all four credits from S, then one enable too many.
    add(1, 3'd1, 0, 1, 0, 0);
    add(1, 3'd1, 0, 1, 0, 0);
    add(1, 3'd1, 0, 1, 0, 0);
    add(1, 3'd1, 0, 1, 1, 0);
    add(1, 3'd1, 0, 0, 1, 1);
    // Empty: enable with return transfers nothing but restores one credit.
    add(1, 3'd0, 1, 0, 0, 1);
    add(1, 3'd2, 0, 1, 1, 1);
    add(0, 3'd0, 1, 0, 0, 1);
    add(1, 3'd4, 0, 1, 1, 1);
    run_tbl();

    // Reset while valid_o is high.
    chk("pre_rst_valid", 16'(valid_o), 16'h0001);
    do_reset("mid_rst");

    add(1, 3'd3, 0, 1, 0, 0);
    add(1, 3'd3, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 3'(i), 1, 1, 0, 0);
    add(0, 3'd0, 1, 0, 0, 0);
    add(0, 3'd0, 1, 0, 0, 0);
    add(0, 3'd0, 1, 0, 0, 1);
    // Saturated at 4: exactly four transfers reach full.
    add(1, 3'd0, 0, 1, 0, 1);
    add(1, 3'd0, 0, 1, 0, 1);
    add(1, 3'd0, 0, 1, 0, 1);
    add(1, 3'd0, 0, 1, 1, 1);
    // Last credit with a same-cycle return stays non-full.
    add(0, 3'd0, 1, 0, 0, 1);
    add(1, 3'd2, 1, 1, 0, 1);
    add(1, 3'd2, 0, 1, 1, 1);
    run_tbl();

    do_reset("rst2");
    add(1, 3'd6, 0, 0, 0, 1);
    add(1, 3'd5, 0, 0, 0, 1);
    add(1, 3'd7, 0, 0, 0, 1);
    add(1, 3'd0, 0, 1, 0, 1);
    add(1, 3'd1, 0, 1, 0, 1);
    add(1, 3'd3, 0, 1, 0, 1);
    add(1, 3'd4, 0, 1, 1, 1);
    add(0, 3'd0, 0, 0, 1, 1);
    add(0, 3'd0, 0, 0, 1, 1);
    add(0, 3'd0, 0, 0, 1, 1);
    run_tbl();

    chk("sb_drained", 16'(exp_q.size()), 16'h0000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
